// File: rtl/l2_responder.sv
// ---------------------------------------------------------------------------
// l2_responder
//   Simple L2 model: accepts L1 commands into a small request FIFO and
//   services them one at a time, each taking LATENCY service cycles followed
//   by a single-cycle response strobe.
//
// Parameters
//   LATENCY  service cycles per request (1..15)
//   DEPTH    request FIFO entries (power of two, 2..8)
//
// Ports
//   clk         sole clock, rising edge
//   clear       synchronous active-high reset
//   cmd_in      command: 0 NOP, 1 READ, 2 WRITE, 3 RFO
//   add_in      26-bit line address accompanying cmd_in
//   req_ready   FIFO has room (registered count < DEPTH)
//   resp_valid  one-cycle completion strobe
//   resp_cmd    completed command (0 when resp_valid=0)
//   resp_add    completed address (0 when resp_valid=0)
//   busy        FSM not idle or FIFO non-empty
//   reads/writes/rfos/drops  saturating statistics counters
//
// Configuration
//   L2_RESPONDER_STATS_EN  when defined, the statistics counters are built;
//                          otherwise the four stats ports are tied to 0.
// ---------------------------------------------------------------------------
module l2_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [1:0]  cmd_in,
    input  logic [25:0] add_in,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [1:0]  resp_cmd,
    output logic [25:0] resp_add,
    output logic        busy,
    output logic [31:0] reads,
    output logic [31:0] writes,
    output logic [31:0] rfos,
    output logic [31:0] drops
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [3:0] CD_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_RFO   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t state;

    // FIFO storage: {cmd, addr}
    logic [27:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [3:0]  countdown;
    logic [1:0]  svc_cmd;
    logic [25:0] svc_add;

    logic        resp_valid_q;
    logic [1:0]  resp_cmd_q;
    logic [25:0] resp_add_q;

    logic fifo_full;
    logic fifo_nonempty;
    logic push;
    logic pop;
    logic drop;

    // Full/empty come only from the registered count, so a pop on the same
    // edge can never make room for a push into a full FIFO.
    assign fifo_full     = (count == FULL_CNT);
    assign fifo_nonempty = (count != '0);

    assign push = !clear && (cmd_in != CMD_NOP) && !fifo_full;
    assign drop = !clear && (cmd_in != CMD_NOP) &&  fifo_full;
    // The head is taken whenever the FSM is ready for new work: from IDLE,
    // or straight out of RESPOND so back-to-back requests skip IDLE.
    assign pop  = !clear && fifo_nonempty && ((state == IDLE) || (state == RESPOND));

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {cmd_in, add_in};
                wr_ptr      <= wr_ptr + 1'b1;   // wraps modulo DEPTH
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Service FSM with registered response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= IDLE;
            countdown    <= '0;
            svc_cmd      <= '0;
            svc_add      <= '0;
            resp_valid_q <= 1'b0;
            resp_cmd_q   <= '0;
            resp_add_q   <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_cmd_q   <= '0;
            resp_add_q   <= '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        {svc_cmd, svc_add} <= mem[rd_ptr];
                        countdown          <= CD_LOAD;
                        state              <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (countdown == '0) begin
                        state        <= RESPOND;
                        resp_valid_q <= 1'b1;
                        resp_cmd_q   <= svc_cmd;
                        resp_add_q   <= svc_add;
                    end else begin
                        countdown <= countdown - 1'b1;
                    end
                end
                RESPOND: begin
                    if (pop) begin
                        {svc_cmd, svc_add} <= mem[rd_ptr];
                        countdown          <= CD_LOAD;
                        state              <= SERVICE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced quiet while clear is held, not just after the edge.
    assign req_ready  = !clear && !fifo_full;
    assign resp_valid = !clear && resp_valid_q;
    assign resp_cmd   = clear ? '0 : resp_cmd_q;
    assign resp_add   = clear ? '0 : resp_add_q;
    assign busy       = !clear && ((state != IDLE) || fifo_nonempty);

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef L2_RESPONDER_STATS_EN
    logic [31:0] reads_q;
    logic [31:0] writes_q;
    logic [31:0] rfos_q;
    logic [31:0] drops_q;
    logic        responding;

    assign responding = (state == RESPOND);

    always_ff @(posedge clk) begin
        if (clear) begin
            reads_q  <= '0;
            writes_q <= '0;
            rfos_q   <= '0;
            drops_q  <= '0;
        end else begin
            if (responding && (svc_cmd == CMD_READ) && (reads_q != '1)) begin
                reads_q <= reads_q + 1'b1;
            end
            if (responding && (svc_cmd == CMD_WRITE) && (writes_q != '1)) begin
                writes_q <= writes_q + 1'b1;
            end
            if (responding && (svc_cmd == CMD_RFO) && (rfos_q != '1)) begin
                rfos_q <= rfos_q + 1'b1;
            end
            if (drop && (drops_q != '1)) begin
                drops_q <= drops_q + 1'b1;
            end
        end
    end

    assign reads  = reads_q;
    assign writes = writes_q;
    assign rfos   = rfos_q;
    assign drops  = drops_q;
`else
    logic unused_drop;
    assign unused_drop = drop;

    assign reads  = '0;
    assign writes = '0;
    assign rfos   = '0;
    assign drops  = '0;
`endif

endmodule

// File: tb/tb_l2_responder.sv
// ---------------------------------------------------------------------------
// tb_l2_responder
//   Directed bench for l2_responder (LATENCY=4, DEPTH=4). Works with the
//   statistics build either enabled or disabled (L2_RESPONDER_STATS_EN).
// ---------------------------------------------------------------------------
module tb_l2_responder;

    localparam int unsigned LAT = 4;
    localparam int unsigned DEP = 4;

`ifdef L2_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        clear;
    logic [1:0]  cmd_in;
    logic [25:0] add_in;
    logic        req_ready;
    logic        resp_valid;
    logic [1:0]  resp_cmd;
    logic [25:0] resp_add;
    logic        busy;
    logic [31:0] reads;
    logic [31:0] writes;
    logic [31:0] rfos;
    logic [31:0] drops;

    l2_responder #(
        .LATENCY(LAT),
        .DEPTH  (DEP)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_in    (cmd_in),
        .add_in    (add_in),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_cmd  (resp_cmd),
        .resp_add  (resp_add),
        .busy      (busy),
        .reads     (reads),
        .writes    (writes),
        .rfos      (rfos),
        .drops     (drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;   // number of rising edges seen

    // responses observed: edge index after which resp_valid was high
    int          rt[$];
    logic [1:0]  rc[$];
    logic [25:0] ra[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n edges; record every response and check idle outputs read 0.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (resp_valid === 1'b1) begin
                rt.push_back(cyc);
                rc.push_back(resp_cmd);
                ra.push_back(resp_add);
            end else begin
                chk("idle_resp_cmd", 32'(resp_cmd), 32'd0);
                chk("idle_resp_add", 32'(resp_add), 32'd0);
            end
        end
    endtask

    task automatic clrq();
        rt.delete();
        rc.delete();
        ra.delete();
    endtask

    function automatic int qt(input int i);
        return (i < rt.size()) ? rt[i] : -1;
    endfunction
    function automatic logic [1:0] qc(input int i);
        return (i < rc.size()) ? rc[i] : 2'bxx;
    endfunction
    function automatic logic [25:0] qa(input int i);
        return (i < ra.size()) ? ra[i] : 26'bx;
    endfunction

    task automatic drive(input logic [1:0] c, input logic [25:0] a);
        cmd_in = c;
        add_in = a;
    endtask

    int e;

    initial begin
        clear  = 1'b1;
        cmd_in = 2'd0;
        add_in = '0;

        // ---- reset state ----
        run(3);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_reads", reads, 32'd0);
        chk("rst_drops", drops, 32'd0);
        clear = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // ---- single READ, unloaded latency ----
        run(9);
        clrq();
        drive(2'd1, 26'h0ABCDEF);
        run(1);
        e = cyc;
        drive(2'd0, '0);
        chk("single_busy", 32'(busy), 32'd1);
        run(LAT + 4);
        chk("single_count", 32'(rt.size()), 32'd1);
        chk("single_time", 32'(qt(0)), 32'(e + LAT + 1));
        chk("single_cmd", 32'(qc(0)), 32'd1);
        chk("single_add", 32'(qa(0)), 32'h0ABCDEF);
        chk("single_reads", reads, STATS ? 32'd1 : 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // ---- six back-to-back WRITEs into DEPTH=4 ----
        clrq();
        e = cyc + 1;
        for (int i = 1; i <= 5; i++) begin
            drive(2'd2, 26'(i));
            run(1);
        end
        chk("full_req_ready", 32'(req_ready), 32'd0);
        drive(2'd2, 26'd6);
        run(1);
        drive(2'd0, '0);
        run(6 * (LAT + 1) + 4);
        chk("b2b_count", 32'(rt.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("b2b_time%0d", k), 32'(qt(k)), 32'(e + LAT + 1 + k * (LAT + 1)));
            chk($sformatf("b2b_cmd%0d", k), 32'(qc(k)), 32'd2);
            chk($sformatf("b2b_add%0d", k), 32'(qa(k)), 32'(k + 1));
        end
        chk("b2b_writes", writes, STATS ? 32'd5 : 32'd0);
        chk("b2b_drops", drops, STATS ? 32'd1 : 32'd0);
        chk("b2b_ready_again", 32'(req_ready), 32'd1);

        // ---- push during RESPOND with one queued entry ----
        clrq();
        drive(2'd1, 26'h0000A0A);
        run(1);
        e = cyc;
        drive(2'd2, 26'h0000B0B);
        run(1);
        drive(2'd0, '0);
        run(LAT);                       // now in A's RESPOND cycle
        chk("rsp_push_valid", 32'(resp_valid), 32'd1);
        drive(2'd3, 26'h0000C0C);
        run(1);
        drive(2'd0, '0);
        run(3 * (LAT + 1));
        chk("rsp_push_count", 32'(rt.size()), 32'd3);
        chk("rsp_push_tA", 32'(qt(0)), 32'(e + LAT + 1));
        chk("rsp_push_tB", 32'(qt(1)), 32'(e + 2 * LAT + 2));
        chk("rsp_push_tC", 32'(qt(2)), 32'(e + 3 * LAT + 3));
        chk("rsp_push_aA", 32'(qa(0)), 32'h0A0A);
        chk("rsp_push_aB", 32'(qa(1)), 32'h0B0B);
        chk("rsp_push_aC", 32'(qa(2)), 32'h0C0C);
        chk("rsp_push_cC", 32'(qc(2)), 32'd3);
        chk("pre_clr_reads", reads, STATS ? 32'd2 : 32'd0);
        chk("pre_clr_writes", writes, STATS ? 32'd6 : 32'd0);
        chk("pre_clr_rfos", rfos, STATS ? 32'd1 : 32'd0);

        // ---- clear during SERVICE with two entries queued ----
        clrq();
        drive(2'd1, 26'd10);
        run(1);
        drive(2'd2, 26'd11);
        run(1);
        drive(2'd3, 26'd12);
        run(1);
        drive(2'd0, '0);
        chk("svc_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        #1;
        chk("clr_req_ready", 32'(req_ready), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_resp_valid", 32'(resp_valid), 32'd0);
        run(1);
        clear = 1'b0;
        #1;
        chk("aclr_busy", 32'(busy), 32'd0);
        chk("aclr_reads", reads, 32'd0);
        chk("aclr_writes", writes, 32'd0);
        chk("aclr_rfos", rfos, 32'd0);
        chk("aclr_drops", drops, 32'd0);
        run(3 * (LAT + 1) + 4);
        chk("aclr_no_resp", 32'(rt.size()), 32'd0);
        chk("aclr_busy_late", 32'(busy), 32'd0);

        drive(2'd3, 26'h3FFFFFF);
        run(1);
        e = cyc;
        drive(2'd0, '0);
        run(LAT + 4);
        chk("rfo_count", 32'(rt.size()), 32'd1);
        chk("rfo_time", 32'(qt(0)), 32'(e + LAT + 1));
        chk("rfo_cmd", 32'(qc(0)), 32'd3);
        chk("rfo_add", 32'(qa(0)), 32'h3FFFFFF);
        chk("rfo_rfos", rfos, STATS ? 32'd1 : 32'd0);
        chk("rfo_reads", reads, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
